// File: rtl/spi_ram_cmd_seq_if.sv
// Host request/response and SPI master hand-off signals for spi_ram_cmd_seq.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the host side; spi_busy/spi_done on the SPI side.
//
// slave modport  : sequencer view (consumes requests, drives the SPI master)
// master modport : environment view (host plus SPI master)
//   req_valid/req_wr/req_addr/req_wdata -> sequencer, req_ready <- sequencer
//   rsp_valid/rsp_rdata/rsp_err          <- sequencer
//   spi_start/spi_data_in                <- sequencer
//   spi_busy/spi_done/spi_data_out       -> sequencer
interface spi_ram_cmd_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;

  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  logic       spi_start;
  logic [9:0] spi_data_in;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_data_out;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  spi_busy, spi_done, spi_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output spi_start, spi_data_in
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    output spi_busy, spi_done, spi_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_ram_cmd_seq.sv
// Sequences one host RAM request into two 10-bit SPI frames (address, then data) and returns a response.
// Latency: accept -> rsp_valid = 2 + 2*(N+1) cycles with spi_busy low and spi_done N cycles after each start.
// Backpressure: req_ready only in IDLE; start held off while spi_busy; rsp_valid is a pulse with no backpressure.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - spi_ram_cmd_seq_if.slave (host request/response + SPI master start/data/busy/done)
//
// Optional build macro SPI_SEQ_TIMEOUT_EN: adds a per-frame watchdog; a frame waiting
// TIMEOUT_CYCLES WAIT cycles without spi_done aborts the request with rsp_err=1.
// Without the macro no counter exists, WAIT states wait forever and rsp_err is 0.
module spi_ram_cmd_seq #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_cmd_seq_if.slave bus
);

  // Frame command codes seen by the slave RAM.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Reject configurations where the watchdog counter cannot reach its limit.
  if (TIMEOUT_CYCLES < 1 || CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cfg_check
    $error("spi_ram_cmd_seq: TIMEOUT_CYCLES must be >= 1 and CNT_W wide enough to hold it");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    F1_START = 3'd1,
    F1_WAIT  = 3'd2,
    F2_START = 3'd3,
    F2_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t     state_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       spi_start_q;
  logic [9:0] spi_data_in_q;
  logic       wr_q;        // captured request direction
  logic [7:0] wdata_q;     // captured write data, needed for the second frame

  // Frame words computed from the live request (F1) and the captured one (F2).
  logic [9:0] frame1_d;
  logic [9:0] frame2_d;
  logic       accept_d;

`ifdef SPI_SEQ_TIMEOUT_EN
  // The counter holds the number of WAIT cycles already spent; the limit is hit
  // on the cycle whose increment would make it equal TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;
`endif

  function automatic logic [9:0] frame1(input logic wr, input logic [7:0] addr);
    return {(wr ? CMD_WR_ADDR : CMD_RD_ADDR), addr};
  endfunction

  function automatic logic [9:0] frame2(input logic wr, input logic [7:0] wdata);
    return wr ? {CMD_WR_DATA, wdata} : {CMD_RD_DATA, 8'h00};
  endfunction

  always_comb begin
    accept_d = 1'b0;
    frame1_d = frame1(bus.req_wr, bus.req_addr);
    frame2_d = frame2(wr_q, wdata_q);
    if (state_q == IDLE && bus.req_valid && req_ready_q) begin
      accept_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      spi_start_q   <= 1'b0;
      spi_data_in_q <= 10'h000;
      wr_q          <= 1'b0;
      wdata_q       <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      // Both pulses last exactly one cycle unless re-asserted below.
      spi_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // Ready comes up one cycle after reset release or after RESP.
          req_ready_q <= 1'b1;
          if (accept_d) begin
            req_ready_q   <= 1'b0;
            wr_q          <= bus.req_wr;
            wdata_q       <= bus.req_wdata;
            spi_data_in_q <= frame1_d;
            state_q       <= F1_START;
          end
        end

        F1_START: begin
          if (!bus.spi_busy) begin
            spi_start_q <= 1'b1;
            state_q     <= F1_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end

        F1_WAIT: begin
          if (bus.spi_done) begin
            spi_data_in_q <= frame2_d;
            state_q       <= F2_START;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            // Abort: the data frame is never issued.
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
`endif
        end

        F2_START: begin
          if (!bus.spi_busy) begin
            spi_start_q <= 1'b1;
            state_q     <= F2_WAIT;
`ifdef SPI_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end

        F2_WAIT: begin
          if (bus.spi_done) begin
            // The response pulse is raised here so it is visible during RESP.
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? 8'h00 : bus.spi_data_out;
`ifdef SPI_SEQ_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= RESP;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
`endif
        end

        RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: begin
          req_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.spi_start   = spi_start_q;
  assign bus.spi_data_in = spi_data_in_q;
`ifdef SPI_SEQ_TIMEOUT_EN
  assign bus.rsp_err     = rsp_err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_cmd_seq.sv
// Self-checking bench for spi_ram_cmd_seq: vector table, directed corner sequences, random requests.
// Latency: n/a (bench).
// Backpressure: bench models the SPI master/RAM with programmable done delay and busy hold-off.
module tb_spi_ram_cmd_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_cmd_seq_if bus ();

  spi_ram_cmd_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start_cnt = 0;
  int rsp_cnt   = 0;
  int epoch     = 0;
  int dly       = 0;
  bit no_done   = 1'b0;

  logic [9:0] frames[$];
  logic [7:0] gold[256];     // request-level memory model
  logic [7:0] slv_ram[256];  // memory behind the modelled SPI slave
  logic [7:0] slv_addr;
  logic [9:0] r_frame;
  int         r_ep;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         dly;
    int         busy;
    logic [9:0] f1;
    logic [9:0] f2;
    logic [7:0] rd;
    int         lat;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.spi_start) start_cnt++;
    if (bus.rsp_valid) rsp_cnt++;
  end

  // SPI master + slave RAM: logs each frame, interprets it, answers after dly cycles.
  always begin
    @(negedge clk);
    if (bus.spi_start) begin
      r_frame = bus.spi_data_in;
      r_ep    = epoch;
      frames.push_back(r_frame);
      case (r_frame[9:8])
        2'b00, 2'b10: slv_addr = r_frame[7:0];
        2'b01:        slv_ram[slv_addr] = r_frame[7:0];
        default:      ;
      endcase
      if (!no_done) begin
        for (int i = 0; i < dly; i++) @(negedge clk);
        if (r_ep == epoch) begin
          check("data_in_held", bus.spi_data_in, r_frame);
          bus.spi_data_out = (r_frame[9:8] == 2'b11) ? slv_ram[slv_addr] : 8'($urandom);
          bus.spi_done     = 1'b1;
          @(negedge clk);
          bus.spi_done     = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] w, input int d,
                        input int b, input logic [9:0] ef1, input logic [9:0] ef2,
                        input logic [7:0] erd, input int elat);
    int n;
    int t_acc;
    dly = d;
    frames.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = w;
    bus.spi_busy  = (b > 0);
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_bound", 32'(n < 100), 32'd1);
    t_acc = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    for (int i = 0; i < b; i++) begin
      check("busy_no_start", bus.spi_start, 1'b0);
      check("busy_data_in", bus.spi_data_in, ef1);
      @(negedge clk);
    end
    bus.spi_busy = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 300) begin @(negedge clk); n++; end
    check("rsp_bound", 32'(n < 300), 32'd1);
    check("latency", cyc - t_acc, elat);
    check("rsp_rdata", bus.rsp_rdata, erd);
    check("rsp_err", bus.rsp_err, 1'b0);
    check("frame_count", frames.size(), 2);
    if (frames.size() >= 2) begin
      check("frame1", frames[0], ef1);
      check("frame2", frames[1], ef2);
    end
    @(negedge clk);
    check("rsp_one_cycle", bus.rsp_valid, 1'b0);
    check("ready_after_resp", bus.req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, s0, r0, acc, ts;
    int acc_cyc[2];
    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 2, 0, 10'h03C, 10'h1A5, 8'h00, 8};
    vecs[1] = '{1'b0, 8'h3C, 8'h00, 1, 0, 10'h23C, 10'h300, 8'hA5, 6};
    vecs[2] = '{1'b1, 8'h10, 8'h77, 0, 5, 10'h010, 10'h177, 8'h00, 9};
    vecs[3] = '{1'b0, 8'h10, 8'h00, 3, 0, 10'h210, 10'h300, 8'h77, 10};
    vecs[4] = '{1'b1, 8'hFF, 8'h00, 0, 0, 10'h0FF, 10'h100, 8'h00, 4};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 0, 2, 10'h2FF, 10'h300, 8'h00, 6};
    vecs[6] = '{1'b1, 8'h00, 8'hFF, 4, 0, 10'h000, 10'h1FF, 8'h00, 12};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 2, 1, 10'h200, 10'h300, 8'hFF, 9};

    for (int i = 0; i < 256; i++) begin
      gold[i]    = 8'($urandom);
      slv_ram[i] = gold[i];
    end
    slv_addr = 8'h00;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    bus.spi_busy  = 1'b0; bus.spi_done = 1'b0; bus.spi_data_out = 8'h00;

    // Reset state
    #8;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_spi_start", bus.spi_start, 1'b0);
    check("rst_spi_data_in", bus.spi_data_in, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", bus.req_ready, 1'b1);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) gold[vecs[i].addr] = vecs[i].wdata;
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].busy,
             vecs[i].f1, vecs[i].f2, vecs[i].rd, vecs[i].lat);
    end

    // Stray done in IDLE, then req_valid held across two requests
    s0 = start_cnt;
    @(negedge clk); bus.spi_done = 1'b1;
    @(negedge clk); bus.spi_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_no_start", start_cnt - s0, 0);
    check("stray_done_ready", bus.req_ready, 1'b1);
    dly = 1;
    s0 = start_cnt; r0 = rsp_cnt; acc = 0; n = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h55; bus.req_wdata = 8'hC3;
    gold[8'h55] = 8'hC3;
    while (acc < 2 && n < 100) begin
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc[acc] = cyc + 1;
        acc++;
      end
      if (acc < 2) @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("held_valid_accepts", acc, 2);
    check("held_valid_gap", acc_cyc[1] - acc_cyc[0], 8);
    check("held_valid_starts", start_cnt - s0, 4);
    check("held_valid_rsps", rsp_cnt - r0, 2);

    // Reset during F2_WAIT of a read
    dly = 20;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h3C;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 100) begin
      @(negedge clk);
      if (bus.spi_start) k++;
      n++;
    end
    check("rst_test_two_starts", k, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    epoch++;
    #1;
    check("midrst_req_ready", bus.req_ready, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    check("midrst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("midrst_spi_start", bus.spi_start, 1'b0);
    check("midrst_spi_data_in", bus.spi_data_in, 10'h000);
    s0 = start_cnt; r0 = rsp_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_rsp", rsp_cnt - r0, 0);
    check("midrst_no_replay", start_cnt - s0, 0);
    do_req(1'b0, 8'h3C, 8'h00, 1, 0, 10'h23C, 10'h300, gold[8'h3C], 6);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: no spi_done for the address frame
    no_done = 1'b1;
    frames.delete();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 8'h20; bus.req_wdata = 8'h11;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.spi_start && n < 50) begin @(negedge clk); n++; end
    ts = cyc;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("timeout_latency", cyc - ts, 16);
    check("timeout_err", bus.rsp_err, 1'b1);
    check("timeout_rdata", bus.rsp_rdata, 8'h00);
    repeat (5) @(negedge clk);
    check("timeout_no_f2", frames.size(), 1);
    no_done = 1'b0;
`else
    ts = 0;
`endif

    // Random requests against the request-level model
    for (int i = 0; i < 40; i++) begin
      bit         wr;
      logic [7:0] a, w, rd;
      logic [9:0] f1, f2;
      int         d, b;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      w  = 8'($urandom);
      d  = $urandom_range(0, 4);
      b  = $urandom_range(0, 3);
      f1 = wr ? {2'b00, a} : {2'b10, a};
      f2 = wr ? {2'b01, w} : {2'b11, 8'h00};
      rd = wr ? 8'h00 : gold[a];
      if (wr) gold[a] = w;
      do_req(wr, a, w, d, b, f1, f2, rd, 2 + 2 * (d + 1) + b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
